adsr_env_gen: RTL and testbench
===============================

# adsr_env_gen

Parametrised four-stage (attack/decay/sustain/release) envelope generator for one synth voice, successor to the single-pole on/off envelope filter. Each stage is a one-pole exponential approach toward a stage target, with a runtime coefficient per stage and a runtime sustain level. It sits between the voice allocator, which supplies the gate and reads `available`, and the operator amplitude multiplier, which reads `envelope`. Updates happen only on the sample-rate strobe.

## Interface
- `NUM_BITS`, 32: width of envelope, coefficients and sustain level; unsigned Q2.(NUM_BITS-2); ONE = 1<<(NUM_BITS-2).
- `ATTACK_TGT`, 0x50000000 (1.25): attack target; must be > ONE so that the attack reaches ONE in finite time.
- `MIN_LVL`, 0x00400000: convergence/silence threshold.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample strobe, one-cycle pulse; all state and envelope updates occur only on cycles with `en`=1.
- `gate` in 1: note on (1) / off (0); level-sensitive, sampled only when `en`=1.
- `attack_coef` in NUM_BITS: attack rate, Q2.(NUM_BITS-2), range 0..ONE.
- `decay_coef` in NUM_BITS: decay rate (also used while in SUSTAIN).
- `release_coef` in NUM_BITS: release rate.
- `sustain_lvl` in NUM_BITS: sustain target; values > ONE are treated as ONE.
- `envelope` out NUM_BITS: registered envelope, range 0..ONE.
- `state` out 3: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE.
- `available` out 1: registered; 1 exactly when `state`=IDLE.

## Operation
- Per-update arithmetic on an `en` cycle: diff = target − env, signed NUM_BITS+2 bits; prod = (coef × diff) arithmetic-shifted right by NUM_BITS-2, floor rounding; nxt = env + prod. Intermediates must be wide enough that no overflow occurs for any legal input.
- Targets: ATTACK → ATTACK_TGT; DECAY/SUSTAIN → min(sustain_lvl, ONE); RELEASE → 0.
- Evaluation order on an `en` cycle: the gate event takes priority over the stage-completion check.
- IDLE: env held at 0. `gate`=1 → ATTACK; env is unchanged on this update (stays 0).
- ATTACK: `gate`=0 → RELEASE with no arithmetic on this update. Otherwise compute nxt; if nxt ≥ ONE then env ← ONE and → DECAY, else env ← nxt.
- DECAY: `gate`=0 → RELEASE. Otherwise env ← nxt; if |nxt − S| < MIN_LVL then env ← S and → SUSTAIN.
- SUSTAIN: `gate`=0 → RELEASE. Otherwise env ← nxt toward the current S using decay_coef, so the envelope glides to a changed sustain_lvl without leaving SUSTAIN.
- RELEASE: `gate`=1 (retrigger) → ATTACK from the current env, with no reset to 0. Otherwise env ← nxt; if nxt < MIN_LVL then env ← 0 and → IDLE.
- A coefficient of 0 stalls the stage: env holds and no transition occurs, except on a gate event.
- A coefficient of ONE jumps to the target in one update.
- Inputs `gate`, coefficients and `sustain_lvl` are sampled only on `en` cycles. Changes between strobes are invisible.
- `rst` has priority over `en` and is honoured mid-stage: state IDLE, envelope 0, available 1.

## Timing
- Reset values: `envelope`=0, `state`=0 (IDLE), `available`=1.
- Latency: the `envelope`/`state`/`available` change produced by an `en` cycle is visible on the next clock edge (1 cycle). All outputs come straight from registers.
- Outputs are stable between strobes. Back-to-back `en` (every cycle) must be supported.
- `available` falls on the same edge that `state` leaves IDLE, and rises on the same edge that `state` enters IDLE.
- Gate-on to first envelope change: 2 strobes (IDLE→ATTACK, then the first ATTACK update).

## Test plan
- Reset/idle: assert `rst` mid-ATTACK with env≈0x20000000 → next edge `envelope`=0, `state`=0, `available`=1. With `gate`=0 and `en` pulsing, outputs stay unchanged.
- Instant stages (NUM_BITS=32): all coefs=0x40000000, sustain=0x20000000, gate held high; strobes 1–4 → state ATTACK/env 0; DECAY/0x40000000; SUSTAIN/0x20000000; SUSTAIN/0x20000000. Gate low → RELEASE/0x20000000, then IDLE/0 with `available`=1.
- Exponential attack: attack_coef=0x10000000 (0.25) from 0 → env 0x14000000, 0x23000000, 0x2E400000, … The first value ≥ 0x40000000 clamps to 0x40000000 and enters DECAY. Compare every step against a bit-exact floor model.
- Retrigger: release_coef=0x04000000, gate low at env=0x40000000; after 8 strobes raise gate → ATTACK starting from the current nonzero env, with no dip to 0.
- Edge cases: decay_coef=0 → env frozen at ONE in DECAY until gate drops. Set sustain_lvl=0x7FFFFFFF → behaves as ONE. While in SUSTAIN, change sustain 0x20000000→0x30000000 → env rises monotonically to 0x30000000 and `state` stays 3.
- Strobe gating: toggle `gate` and all coefs on non-`en` cycles only → outputs unchanged. Run `en` every cycle vs. every 48 cycles → identical per-strobe envelope sequences.

Source files
------------

// File: rtl/adsr_env_gen_if.sv
// Voice-side bus of the ADSR envelope generator: sample strobe, gate,
// per-stage coefficients and sustain level in; envelope, stage and availability out.
interface adsr_env_gen_if #(
  parameter int NUM_BITS = 32
);
  logic                en;
  logic                gate;
  logic [NUM_BITS-1:0] attack_coef;
  logic [NUM_BITS-1:0] decay_coef;
  logic [NUM_BITS-1:0] release_coef;
  logic [NUM_BITS-1:0] sustain_lvl;
  logic [NUM_BITS-1:0] envelope;
  logic [2:0]          state;
  logic                available;

  modport master (
    output en, gate, attack_coef, decay_coef, release_coef, sustain_lvl,
    input  envelope, state, available
  );

  modport slave (
    input  en, gate, attack_coef, decay_coef, release_coef, sustain_lvl,
    output envelope, state, available
  );
endinterface

// File: rtl/adsr_env_gen.sv
// Four-stage ADSR envelope for one voice: each stage is a one-pole exponential
// approach toward its target, advanced only on the sample strobe.
module adsr_env_gen #(
  parameter int                  NUM_BITS   = 32,
  parameter logic [NUM_BITS-1:0] ATTACK_TGT = 32'h5000_0000,
  parameter logic [NUM_BITS-1:0] MIN_LVL    = 32'h0040_0000
) (
  input  logic           clk,
  input  logic           rst,
  adsr_env_gen_if.slave  env_bus
);
  localparam int W  = NUM_BITS;
  localparam int DW = NUM_BITS + 2;      // signed difference / next-value width
  localparam int PW = 2 * NUM_BITS + 3;  // full coefficient x difference product

  localparam logic [W-1:0] ONE = {2'b01, {(W-2){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_t;

  stage_t          state_reg;
  logic [W-1:0]    env_reg;
  logic            available_reg;

  logic [W-1:0]    sustain_tgt;
  logic [W-1:0]    target;
  logic [W-1:0]    coef;
  logic            coef_zero;
  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] coef_ext;
  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] prod_full;
  logic signed [DW-1:0] step;
  logic signed [DW-1:0] env_next;
  logic signed [DW-1:0] dev;
  logic signed [DW-1:0] dev_abs;
  logic            reach_one;
  logic            near_sustain;
  logic            below_min;

  always_comb begin
    sustain_tgt = (env_bus.sustain_lvl > ONE) ? ONE : env_bus.sustain_lvl;
    target      = '0;
    coef        = env_bus.release_coef;
    case (state_reg)
      ST_ATTACK: begin
        target = ATTACK_TGT;
        coef   = env_bus.attack_coef;
      end
      ST_DECAY, ST_SUSTAIN: begin
        target = sustain_tgt;
        coef   = env_bus.decay_coef;
      end
      default: begin
        target = '0;
        coef   = env_bus.release_coef;
      end
    endcase
    coef_zero = (coef == '0);

    // Arithmetic right shift of the signed product gives floor rounding.
    diff      = $signed({2'b00, target}) - $signed({2'b00, env_reg});
    coef_ext  = $signed({{(PW-W){1'b0}}, coef});
    diff_ext  = {{(PW-DW){diff[DW-1]}}, diff};
    prod_full = coef_ext * diff_ext;
    step      = DW'(prod_full >>> (W-2));
    env_next  = $signed({2'b00, env_reg}) + step;

    dev          = env_next - $signed({2'b00, sustain_tgt});
    dev_abs      = dev[DW-1] ? -dev : dev;
    reach_one    = (env_next >= $signed({2'b00, ONE}));
    near_sustain = (dev_abs < $signed({2'b00, MIN_LVL}));
    below_min    = (env_next < $signed({2'b00, MIN_LVL}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      env_reg       <= '0;
      available_reg <= 1'b1;
    end else if (env_bus.en) begin
      case (state_reg)
        ST_IDLE: begin
          env_reg <= '0;
          if (env_bus.gate) begin
            state_reg     <= ST_ATTACK;
            available_reg <= 1'b0;
          end
        end
        ST_ATTACK: begin
          if (!env_bus.gate) begin
            state_reg <= ST_RELEASE;
          end else if (!coef_zero) begin
            if (reach_one) begin
              env_reg   <= ONE;
              state_reg <= ST_DECAY;
            end else begin
              env_reg <= env_next[W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (!env_bus.gate) begin
            state_reg <= ST_RELEASE;
          end else if (!coef_zero) begin
            if (near_sustain) begin
              env_reg   <= sustain_tgt;
              state_reg <= ST_SUSTAIN;
            end else begin
              env_reg <= env_next[W-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          // Keeps tracking the live sustain level so level changes glide.
          if (!env_bus.gate) begin
            state_reg <= ST_RELEASE;
          end else if (!coef_zero) begin
            env_reg <= env_next[W-1:0];
          end
        end
        ST_RELEASE: begin
          if (env_bus.gate) begin
            state_reg <= ST_ATTACK;
          end else if (!coef_zero) begin
            if (below_min) begin
              env_reg       <= '0;
              state_reg     <= ST_IDLE;
              available_reg <= 1'b1;
            end else begin
              env_reg <= env_next[W-1:0];
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          env_reg       <= '0;
          available_reg <= 1'b1;
        end
      endcase
    end
  end

  assign env_bus.envelope  = env_reg;
  assign env_bus.state     = state_reg;
  assign env_bus.available = available_reg;
endmodule

// File: tb/tb_adsr_env_gen.sv
// Scoreboard bench for adsr_env_gen: a floor-exact model predicts each strobe,
// predictions are queued at drive time and popped when the DUT output settles.
module tb_adsr_env_gen;
  localparam int     NB      = 32;
  localparam longint ONE     = 64'h4000_0000;
  localparam longint ATT_TGT = 64'h5000_0000;
  localparam longint MINL    = 64'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adsr_env_gen_if #(.NUM_BITS(NB)) env_bus ();

  adsr_env_gen #(
    .NUM_BITS  (NB),
    .ATTACK_TGT(32'h5000_0000),
    .MIN_LVL   (32'h0040_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .env_bus(env_bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_strobes = 0;

  // stimulus currently applied on strobes
  logic        g;
  logic [31:0] ac, dc, rc, sl;

  // reference model state
  int     m_st;
  longint m_env;

  int     q_st[$];
  longint q_env[$];

  longint seq[2][24];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint approach(input longint e, input longint tgt, input longint c);
    return e + ((c * (tgt - e)) >>> 30);
  endfunction

  task automatic model_step();
    longint s, nxt, d;
    s = longint'(sl);
    if (s > ONE) s = ONE;
    case (m_st)
      0: begin
        m_env = 0;
        if (g) m_st = 1;
      end
      1: begin
        if (!g) m_st = 4;
        else if (ac != 0) begin
          nxt = approach(m_env, ATT_TGT, longint'(ac));
          if (nxt >= ONE) begin m_env = ONE; m_st = 2; end
          else m_env = nxt;
        end
      end
      2: begin
        if (!g) m_st = 4;
        else if (dc != 0) begin
          nxt = approach(m_env, s, longint'(dc));
          d = nxt - s;
          if (d < 0) d = -d;
          if (d < MINL) begin m_env = s; m_st = 3; end
          else m_env = nxt;
        end
      end
      3: begin
        if (!g) m_st = 4;
        else if (dc != 0) m_env = approach(m_env, s, longint'(dc));
      end
      default: begin
        if (g) m_st = 1;
        else if (rc != 0) begin
          nxt = approach(m_env, 0, longint'(rc));
          if (nxt < MINL) begin m_env = 0; m_st = 0; end
          else m_env = nxt;
        end
      end
    endcase
  endtask

  // gap non-strobe cycles with scrambled inputs, then one strobe
  task automatic strobe(input int gap);
    int     e_st;
    longint e_env;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      env_bus.en           = 1'b0;
      env_bus.gate         = 1'($urandom);
      env_bus.attack_coef  = $urandom;
      env_bus.decay_coef   = $urandom;
      env_bus.release_coef = $urandom;
      env_bus.sustain_lvl  = $urandom;
      @(posedge clk);
      #1;
      check("hold_env", env_bus.envelope, m_env);
      check("hold_st", env_bus.state, m_st);
    end
    @(negedge clk);
    env_bus.en           = 1'b1;
    env_bus.gate         = g;
    env_bus.attack_coef  = ac;
    env_bus.decay_coef   = dc;
    env_bus.release_coef = rc;
    env_bus.sustain_lvl  = sl;
    model_step();
    q_st.push_back(m_st);
    q_env.push_back(m_env);
    @(posedge clk);
    #1;
    e_st  = q_st.pop_front();
    e_env = q_env.pop_front();
    n_strobes++;
    $display("strobe %0d gate=%0b st=%0d env=%08h avail=%0b", n_strobes, g,
             env_bus.state, env_bus.envelope, env_bus.available);
    check("sb_env", env_bus.envelope, e_env);
    check("sb_st", env_bus.state, e_st);
    check("sb_avail", env_bus.available, (e_st == 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    env_bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst   = 1'b0;
    m_st  = 0;
    m_env = 0;
    q_st.delete();
    q_env.delete();
  endtask

  task automatic run_program(input int gap, input int slot);
    do_reset();
    ac = 32'h1000_0000; dc = 32'h0800_0000; rc = 32'h0600_0000; sl = 32'h1800_0000;
    for (int i = 0; i < 24; i++) begin
      g = (i < 16);
      strobe(gap);
      seq[slot][i] = longint'(env_bus.envelope);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint prev;
    int     budget;
    rst = 1'b1;
    env_bus.en = 1'b0; env_bus.gate = 1'b0;
    env_bus.attack_coef = '0; env_bus.decay_coef = '0;
    env_bus.release_coef = '0; env_bus.sustain_lvl = '0;
    g = 1'b0; ac = '0; dc = '0; rc = '0; sl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_env", env_bus.envelope, 0);
    check("rst_st", env_bus.state, 0);
    check("rst_avail", env_bus.available, 1);
    do_reset();

    // idle with gate low
    for (int i = 0; i < 3; i++) strobe(0);
    check("idle_st", env_bus.state, 0);

    // instant stages
    ac = 32'h4000_0000; dc = 32'h4000_0000; rc = 32'h4000_0000; sl = 32'h2000_0000; g = 1'b1;
    strobe(0); check("inst1_st", env_bus.state, 1); check("inst1_env", env_bus.envelope, 0);
    strobe(0); check("inst2_st", env_bus.state, 2); check("inst2_env", env_bus.envelope, 32'h4000_0000);
    strobe(0); check("inst3_st", env_bus.state, 3); check("inst3_env", env_bus.envelope, 32'h2000_0000);
    strobe(0); check("inst4_st", env_bus.state, 3); check("inst4_env", env_bus.envelope, 32'h2000_0000);
    g = 1'b0;
    strobe(0); check("inst_rel_st", env_bus.state, 4); check("inst_rel_env", env_bus.envelope, 32'h2000_0000);
    strobe(0); check("inst_idle_st", env_bus.state, 0); check("inst_idle_env", env_bus.envelope, 0);
    check("inst_idle_avail", env_bus.available, 1);

    // exponential attack into decay and sustain
    ac = 32'h1000_0000; dc = 32'h1000_0000; sl = 32'h2000_0000; g = 1'b1;
    strobe(0);
    strobe(0); check("att1_env", env_bus.envelope, 32'h1400_0000);
    strobe(0); check("att2_env", env_bus.envelope, 32'h2300_0000);
    strobe(0); check("att3_env", env_bus.envelope, 32'h2E40_0000);
    budget = 40;
    while (env_bus.state == 3'd1 && budget > 0) begin strobe(0); budget--; end
    check("att_clamp_st", env_bus.state, 2);
    check("att_clamp_env", env_bus.envelope, 32'h4000_0000);
    budget = 100;
    while (env_bus.state == 3'd2 && budget > 0) begin strobe(0); budget--; end
    check("dec_done_st", env_bus.state, 3);
    check("dec_done_env", env_bus.envelope, 32'h2000_0000);

    // sustain glide to a higher level
    sl = 32'h3000_0000;
    for (int i = 0; i < 80; i++) begin
      prev = longint'(env_bus.envelope);
      strobe(0);
      check("glide_mono", (longint'(env_bus.envelope) >= prev) ? 1 : 0, 1);
      check("glide_st", env_bus.state, 3);
    end
    dc = 32'h4000_0000;
    strobe(0); check("glide_final", env_bus.envelope, 32'h3000_0000);

    // oversized sustain acts as ONE, then release and retrigger
    sl = 32'h7FFF_FFFF;
    strobe(0); check("sus_clamp_env", env_bus.envelope, 32'h4000_0000);
    check("sus_clamp_st", env_bus.state, 3);
    g = 1'b0; rc = 32'h0400_0000;
    strobe(0); check("rel_entry_env", env_bus.envelope, 32'h4000_0000);
    check("rel_entry_st", env_bus.state, 4);
    for (int i = 0; i < 8; i++) strobe(0);
    prev = longint'(env_bus.envelope);
    g = 1'b1; ac = 32'h1000_0000;
    strobe(0);
    check("retrig_st", env_bus.state, 1);
    check("retrig_env", env_bus.envelope, prev);
    check("retrig_nonzero", (env_bus.envelope != 0) ? 1 : 0, 1);
    strobe(0);
    check("retrig_rise", (longint'(env_bus.envelope) > prev) ? 1 : 0, 1);

    // zero decay coefficient freezes DECAY at ONE
    do_reset();
    ac = 32'h4000_0000; dc = 32'h0; sl = 32'h2000_0000; g = 1'b1;
    strobe(0);
    strobe(0);
    for (int i = 0; i < 5; i++) begin
      strobe(0);
      check("dec0_st", env_bus.state, 2);
      check("dec0_env", env_bus.envelope, 32'h4000_0000);
    end
    g = 1'b0;
    strobe(0); check("dec0_rel_st", env_bus.state, 4);

    // reset mid-attack while a strobe is present
    do_reset();
    ac = 32'h1000_0000; g = 1'b1;
    strobe(0); strobe(0); strobe(0);
    check("mid_att_env", env_bus.envelope, 32'h2300_0000);
    @(negedge clk);
    rst = 1'b1; env_bus.en = 1'b1; env_bus.gate = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_env", env_bus.envelope, 0);
    check("mid_rst_st", env_bus.state, 0);
    check("mid_rst_avail", env_bus.available, 1);
    @(negedge clk);
    rst = 1'b0; env_bus.en = 1'b0;
    m_st = 0; m_env = 0;
    g = 1'b0;
    for (int i = 0; i < 3; i++) strobe(3);

    // strobe every cycle vs every 48 cycles
    run_program(0, 0);
    run_program(47, 1);
    for (int i = 0; i < 24; i++) check("rate_equiv", seq[1][i], seq[0][i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
